// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory handshake bridge.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;
    localparam logic [1:0]  WORD_ALIGN_MASK   = 2'b11;

    // A word access is legal only when the low address bits are zero.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// Saturating wait-cycle counter with an expiry flag on the last allowed cycle.
// LIMIT = 0 disables expiry entirely.
module bus_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] CNT_MAX  = W'(LIMIT);
    localparam logic [W-1:0] CNT_LAST = (LIMIT < 1) ? '0 : W'(LIMIT - 1);

    logic [W-1:0] count_reg;

    // Count enabled cycles, stop at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != CNT_MAX)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && (count_reg == CNT_LAST);

endmodule

// File: rtl/dmem_handshake_bridge.sv
// Bridges the single-cycle core's data port to a req/ack data memory,
// freezing the core through stall until each lw/sw completes.
module dmem_handshake_bridge
    import mips_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        align_err,
    output logic        timeout_err
);

    state_t      state_reg, state_next;
    logic        req_reg, req_next;
    logic        we_reg, we_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rdata_reg, rdata_next;
    logic        align_err_reg, align_err_next;
    logic        timeout_err_reg, timeout_err_next;

    logic access;
    logic misaligned;
    logic ctr_clr;
    logic ctr_en;
    logic expired;

    // Write wins when both decode lines are up, so cpu_write alone picks mem_we.
    assign access     = cpu_read | cpu_write;
    assign misaligned = is_misaligned(cpu_addr);

    // Counter restarts on every new request and runs only while waiting.
    assign ctr_clr = (state_reg == IDLE);
    assign ctr_en  = (state_reg == BUSY) && !mem_ack;

    bus_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .expired (expired)
    );

    // State and bus-side registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_reg         <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rdata_reg       <= '0;
            align_err_reg   <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            req_reg         <= req_next;
            we_reg          <= we_next;
            addr_reg        <= addr_next;
            wdata_reg       <= wdata_next;
            rdata_reg       <= rdata_next;
            align_err_reg   <= align_err_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // Next-state and registered-output logic; stall is driven combinationally.
    always_comb begin
        state_next       = state_reg;
        req_next         = req_reg;
        we_next          = we_reg;
        addr_next        = addr_reg;
        wdata_next       = wdata_reg;
        rdata_next       = rdata_reg;
        align_err_next   = align_err_reg;
        timeout_err_next = timeout_err_reg;
        stall            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (access) begin
                    stall = 1'b1;
                    if (misaligned) begin
                        align_err_next = 1'b1;
                        rdata_next     = ERR_RDATA;
                        state_next     = DONE;
                    end else begin
                        addr_next  = {cpu_addr[31:2], 2'b00};
                        wdata_next = cpu_wdata;
                        we_next    = cpu_write;
                        req_next   = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    rdata_next = mem_rdata;
                    req_next   = 1'b0;
                    state_next = DONE;
                end else if (expired) begin
                    timeout_err_next = 1'b1;
                    rdata_next       = ERR_RDATA;
                    req_next         = 1'b0;
                    state_next       = DONE;
                end
            end
            DONE: begin
                // Core commits this cycle; the next instruction is evaluated fresh.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    assign cpu_rdata   = rdata_reg;
    assign mem_req     = req_reg;
    assign mem_we      = we_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign align_err   = align_err_reg;
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_dmem_handshake_bridge.sv
// Directed self-checking bench for dmem_handshake_bridge. A second instance
// with a short timeout exercises the abort path.
module tb_dmem_handshake_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack, mem_ack_to;

    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        stall, mem_req, mem_we, align_err, timeout_err;

    logic [31:0] cpu_rdata_to, mem_addr_to, mem_wdata_to;
    logic        stall_to, mem_req_to, mem_we_to, align_err_to, timeout_err_to;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_handshake_bridge dut (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .align_err(align_err), .timeout_err(timeout_err)
    );

    dmem_handshake_bridge #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .reset(reset),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_to), .stall(stall_to),
        .mem_req(mem_req_to), .mem_we(mem_we_to),
        .mem_addr(mem_addr_to), .mem_wdata(mem_wdata_to),
        .mem_ack(mem_ack_to), .mem_rdata(mem_rdata),
        .align_err(align_err_to), .timeout_err(timeout_err_to)
    );

    // Advance one clock; inputs are driven #1 after the edge, checks follow #1 later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
        mem_ack = 1'b0; mem_ack_to = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++;
        if ({stall, mem_req, mem_we, align_err, timeout_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got stall=%b req=%b we=%b ae=%b te=%b want all 0",
                     stall, mem_req, mem_we, align_err, timeout_err);
        end
        checks++;
        if ({mem_addr, mem_wdata, cpu_rdata} !== 96'h0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, cpu_rdata);
        end
        checks++;
        if ({stall_to, mem_req_to, timeout_err_to, cpu_rdata_to} !== 35'h0) begin
            failures++;
            $display("FAIL reset_to got stall=%b req=%b te=%b rdata=%h want 0",
                     stall_to, mem_req_to, timeout_err_to, cpu_rdata_to);
        end
        $display("txn reset done");
    endtask

    task automatic test_aligned_read();
        cpu_read = 1'b1; cpu_addr = 32'h10; settle();
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL rd_idle_stall got %b want 1", stall); end
        step();
        mem_ack = 1'b1; mem_rdata = 32'h12345678; settle();
        checks++;
        if ({stall, mem_req, mem_we} !== 3'b110 || mem_addr !== 32'h10) begin
            failures++;
            $display("FAIL rd_busy got stall=%b req=%b we=%b addr=%h want 1 1 0 00000010",
                     stall, mem_req, mem_we, mem_addr);
        end
        step();
        mem_ack = 1'b0; cpu_read = 1'b0; settle();
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || cpu_rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL rd_done got stall=%b req=%b rdata=%h want 0 0 12345678", stall, mem_req, cpu_rdata);
        end
        step(); settle();
        checks++;
        if (stall !== 1'b0) begin failures++; $display("FAIL rd_after got stall=%b want 0", stall); end
        $display("txn lw addr=00000010 rdata=%h", cpu_rdata);
    endtask

    task automatic test_write_delay();
        int stall_cycles = 0;
        int req_cycles = 0;
        cpu_write = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hA5A5A5A5; settle();
        if (stall === 1'b1) stall_cycles++;
        step();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) mem_ack = 1'b1;
            settle();
            if (stall === 1'b1) stall_cycles++;
            if (mem_req === 1'b1) req_cycles++;
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hA5A5A5A5) begin
                failures++;
                $display("FAIL wr_hold cyc=%0d got req=%b we=%b addr=%h wdata=%h want 1 1 00000020 a5a5a5a5",
                         k, mem_req, mem_we, mem_addr, mem_wdata);
            end
            step();
        end
        mem_ack = 1'b0; cpu_write = 1'b0; settle();
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL wr_done got stall=%b req=%b want 0 0", stall, mem_req);
        end
        checks++;
        if (stall_cycles != 6 || req_cycles != 5) begin
            failures++;
            $display("FAIL wr_latency got stall=%0d req=%0d want 6 5", stall_cycles, req_cycles);
        end
        step();
        $display("txn sw addr=00000020 wdata=a5a5a5a5 stall_cycles=%0d", stall_cycles);
    endtask

    task automatic test_misaligned();
        cpu_read = 1'b1; cpu_addr = 32'h13; settle();
        checks++;
        if (stall !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mis_idle got stall=%b req=%b want 1 0", stall, mem_req);
        end
        step();
        cpu_read = 1'b0; settle();
        checks++;
        if (stall !== 1'b0 || mem_req !== 1'b0 || align_err !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL mis_done got stall=%b req=%b ae=%b rdata=%h want 0 0 1 deadbeef",
                     stall, mem_req, align_err, cpu_rdata);
        end
        step();
        $display("txn lw addr=00000013 misaligned rdata=%h", cpu_rdata);
    endtask

    task automatic test_reset_mid_busy();
        cpu_read = 1'b1; cpu_addr = 32'h40; settle();
        step(); step();
        checks++;
        if (mem_req !== 1'b1 || align_err !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got req=%b ae=%b want 1 1", mem_req, align_err);
        end
        reset = 1'b1; cpu_read = 1'b0;
        step();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h11111111; settle();
        checks++;
        if ({mem_req, stall, align_err, timeout_err, timeout_err_to} !== 5'b0) begin
            failures++;
            $display("FAIL rst_mid got req=%b stall=%b ae=%b te=%b te_to=%b want 0",
                     mem_req, stall, align_err, timeout_err, timeout_err_to);
        end
        step();
        mem_ack = 1'b0; settle();
        checks++;
        if (mem_req !== 1'b0 || stall !== 1'b0 || cpu_rdata !== 32'h0) begin
            failures++;
            $display("FAIL rst_late_ack got req=%b stall=%b rdata=%h want 0 0 00000000", mem_req, stall, cpu_rdata);
        end
        $display("txn reset during busy");
    endtask

    task automatic test_back_to_back();
        int req_cycles = 0;
        cpu_read = 1'b1; cpu_addr = 32'h8; settle();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; settle();
        if (mem_req === 1'b1) req_cycles++;
        step();
        mem_ack = 1'b0; settle();
        checks++;
        if (stall !== 1'b0 || cpu_rdata !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL b2b_done got stall=%b rdata=%h want 0 cafef00d", stall, cpu_rdata);
        end
        step();
        cpu_read = 1'b0; settle();
        for (int k = 0; k < 3; k++) begin
            if (mem_req === 1'b1) req_cycles++;
            checks++;
            if (stall !== 1'b0) begin failures++; $display("FAIL b2b_add_stall cyc=%0d got %b want 0", k, stall); end
            step(); settle();
        end
        checks++;
        if (req_cycles != 1) begin failures++; $display("FAIL b2b_txn_count got %0d want 1", req_cycles); end
        $display("txn lw then add req_cycles=%0d", req_cycles);
    endtask

    task automatic test_timeout();
        apply_reset();
        cpu_read = 1'b1; cpu_addr = 32'h30; settle();
        step();
        for (int k = 1; k <= 4; k++) begin
            settle();
            checks++;
            if (mem_req_to !== 1'b1 || timeout_err_to !== 1'b0 || stall_to !== 1'b1) begin
                failures++;
                $display("FAIL to_busy cyc=%0d got req=%b te=%b stall=%b want 1 0 1",
                         k, mem_req_to, timeout_err_to, stall_to);
            end
            step();
        end
        cpu_read = 1'b0; mem_ack_to = 1'b1; mem_rdata = 32'h55555555; settle();
        checks++;
        if (mem_req_to !== 1'b0 || timeout_err_to !== 1'b1 || stall_to !== 1'b0 || cpu_rdata_to !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL to_done got req=%b te=%b stall=%b rdata=%h want 0 1 0 deadbeef",
                     mem_req_to, timeout_err_to, stall_to, cpu_rdata_to);
        end
        step();
        mem_ack_to = 1'b0; settle();
        checks++;
        if (mem_req_to !== 1'b0 || stall_to !== 1'b0 || cpu_rdata_to !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL to_late_ack got req=%b stall=%b rdata=%h want 0 0 deadbeef",
                     mem_req_to, stall_to, cpu_rdata_to);
        end
        $display("txn lw addr=00000030 timeout rdata=%h", cpu_rdata_to);
    endtask

    initial begin
        test_reset();
        test_aligned_read();
        test_write_delay();
        test_misaligned();
        test_reset_mid_busy();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_handshake_bridge.md
Name: dmem_handshake_bridge

Overview:
- Sits between the single-cycle core's data-memory port (address = ALU result, write data = RD2, MemWrite, lw decode) and a variable-latency data memory that uses a req/ack handshake.
- Converts each lw/sw into one handshake transaction.
- Holds the core frozen through `stall` until the transaction completes.
- Flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY without mem_ack before abort. 0 disables the timeout.
- ERR_RDATA, 32'hDEADBEEF: read data returned on an aborted or misaligned read.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- cpu_read  in  1  current instruction is lw
- cpu_write  in  1  current instruction is sw
- cpu_addr  in  32  byte address from ALU
- cpu_wdata  in  32  store data (RD2)
- cpu_rdata  out  32  load data to writeback mux
- stall  out  1  freeze PC, RegWrite and MemWrite in the core
- mem_req  out  1  request to memory (registered)
- mem_we  out  1  1 = write, 0 = read (registered)
- mem_addr  out  32  word-aligned byte address (registered)
- mem_wdata  out  32  write data (registered)
- mem_ack  in  1  one-cycle completion pulse from memory
- mem_rdata  in  32  read data, valid when mem_ack = 1
- align_err  out  1  sticky: misaligned access seen
- timeout_err  out  1  sticky: transaction aborted by timeout

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- Reset values: state = IDLE; mem_req = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; rdata_q = 0; align_err = 0; timeout_err = 0; timeout counter = 0.
  - `stall` is combinational and therefore 0 in reset, since state is IDLE and the core is in reset.
- Reset mid-transaction: state returns to IDLE and mem_req drops at the same edge. Any later mem_ack is ignored.
- Access detection: access = cpu_read | cpu_write.
  - If both are high, write wins and the access is treated as a sw.
- IDLE:
  - access = 0: stall = 0, no action.
  - access = 1: stall = 1 combinationally in the same cycle.
  - access = 1 and cpu_addr[1:0] != 0: no request is issued. Set align_err, load rdata_q = ERR_RDATA, next state DONE.
  - access = 1 and address aligned: latch mem_addr, mem_wdata and mem_we; set mem_req = 1; clear the counter; next state BUSY.
- BUSY:
  - stall = 1. mem_req, mem_addr, mem_we and mem_wdata are held stable until ack.
  - mem_ack = 1: rdata_q <= mem_rdata (don't-care for writes), mem_req <= 0, next state DONE.
  - No ack, TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: timeout_err <= 1, rdata_q <= ERR_RDATA, mem_req <= 0, next state DONE.
  - Otherwise the counter increments.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE:
  - stall = 0. cpu_rdata = rdata_q, so the core commits writeback and advances PC at this edge.
  - Next state is IDLE unconditionally, so the next instruction is evaluated fresh.
- cpu_rdata = rdata_q in all states.
- mem_ack is ignored outside BUSY.
- Latency:
  - Aligned access with ack in the first BUSY cycle: 2 stall cycles (IDLE, BUSY), then 1 commit cycle.
  - Each extra ack delay cycle adds 1 stall cycle.
  - Misaligned access: 1 stall cycle.
  - Non-memory instructions: 0 stall cycles.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1. The counter saturates and never wraps.
- Sticky error flags are cleared only by reset.

Decomposition:
- Shared package (mips_pkg), which holds:
  - state enum: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2
  - ERR_RDATA default constant
  - WORD_ALIGN_MASK = 2'b11
- One sub-module, bus_timeout_ctr (ports: clk, reset, clr, en, expired; parameter LIMIT). It contains the saturating counter and its expiry compare; LIMIT = 0 ties expired to 0.

Test Plan:
- Aligned read, ack one cycle after req: cpu_read = 1, addr = 0x10, mem_rdata = 0x12345678.
  - Expect stall high for 2 cycles, mem_addr = 0x10 and mem_we = 0 while req is high.
  - Expect cpu_rdata = 0x12345678 in DONE, then stall = 0.
- Write with 5-cycle ack delay: cpu_write = 1, addr = 0x20, wdata = 0xA5A5A5A5.
  - Expect mem_req held 5 cycles with stable addr/wdata and mem_we = 1, and 6 stall cycles total.
- Misaligned read, addr = 0x13:
  - Expect mem_req never asserted, align_err = 1, 1 stall cycle, cpu_rdata = 0xDEADBEEF.
- Timeout with TIMEOUT_CYCLES = 4 and no ack:
  - Expect mem_req high for exactly 4 cycles, timeout_err = 1, cpu_rdata = 0xDEADBEEF in DONE.
  - Expect an ack arriving a cycle later to be ignored.
- Reset asserted in the second BUSY cycle:
  - Expect mem_req = 0, stall = 0 and both err flags = 0 after the edge.
  - Expect a following mem_ack to have no effect.
- Back-to-back lw then add, with cpu_read = 1 for one instruction then 0:
  - Expect exactly one transaction and no stall on the add.
